// File: rtl/job_loader.sv
// Job loader: parses framed job bytes, validates the XOR checksum, commits the job
// to registered outputs shared by all mining cores and drives the core enable.
module job_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned RESTART_CYCLES = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_valid,
  output logic             o_rx_ready,
  output logic [7:0]       o_d1,
  output logic [7:0]       o_d2,
  output logic [3:0][7:0]  o_op,
  output logic [7:0]       o_flags,
  output logic [3:0][7:0]  o_expire,
  output logic [31:0][7:0] o_myaddr,
  output logic [31:0][7:0] o_rdata,
  output logic [15:0][7:0] o_pseed,
  output logic [31:0][7:0] o_target,
  output logic             o_enable,
  output logic [7:0]       o_job_id,
  output logic [7:0]       o_err_cnt
);

  localparam int unsigned PayloadLen = 123;
  localparam int unsigned TmoW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned RstW       = (RESTART_CYCLES > 1) ? $clog2(RESTART_CYCLES) : 1;

  typedef enum logic [2:0] {StHunt, StCmd, StPayload, StCsum, StCommit, StRestart} state_e;

  state_e          state_q, state_d;
  logic [6:0]      idx_q, idx_d;
  logic [7:0]      xor_q, xor_d;
  logic            load_q, load_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [RstW-1:0] rst_q, rst_d;
  logic            en_q, en_d;
  logic [7:0]      id_q, id_d;
  logic [7:0]      err_q, err_d;
  logic            err_inc, shadow_we, commit, xfer, active;

  logic [7:0] shadow_q [PayloadLen];
  logic [7:0] job_q    [PayloadLen];

  // Ready only while parsing; forced low during the reset cycle itself.
  always_comb begin
    active     = (state_q == StCmd) || (state_q == StPayload) || (state_q == StCsum);
    o_rx_ready = !i_reset && (active || state_q == StHunt);
    xfer       = i_rx_valid && o_rx_ready;
  end

  // Next-state logic for the frame parser, restart window and counters.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    xor_d     = xor_q;
    load_d    = load_q;
    tmo_d     = '0;
    rst_d     = rst_q;
    en_d      = en_q;
    id_d      = id_q;
    err_inc   = 1'b0;
    shadow_we = 1'b0;
    commit    = 1'b0;
    unique case (state_q)
      StHunt: if (xfer && i_rx_data == 8'hA5) state_d = StCmd;
      StCmd: begin
        if (xfer) begin
          if (i_rx_data == 8'h01) begin
            load_d  = 1'b1;
            xor_d   = 8'h01;
            idx_d   = '0;
            state_d = StPayload;
          end else if (i_rx_data == 8'h02) begin
            load_d  = 1'b0;
            xor_d   = 8'h02;
            state_d = StCsum;
          end else begin
            err_inc = 1'b1;
            state_d = StHunt;
          end
        end
      end
      StPayload: begin
        // 0xA5 is plain data here; no resync inside a payload.
        if (xfer) begin
          shadow_we = 1'b1;
          xor_d     = xor_q ^ i_rx_data;
          idx_d     = idx_q + 7'd1;
          if (idx_q == 7'(PayloadLen - 1)) state_d = StCsum;
        end
      end
      StCsum: begin
        if (xfer) begin
          if (i_rx_data == xor_q) begin
            if (load_q) begin
              state_d = StCommit;
            end else begin
              en_d    = 1'b0;
              state_d = StHunt;
            end
          end else begin
            err_inc = 1'b1;
            state_d = StHunt;
          end
        end
      end
      StCommit: begin
        commit  = 1'b1;
        en_d    = 1'b0;
        id_d    = id_q + 8'd1;
        rst_d   = RstW'(RESTART_CYCLES - 1);
        state_d = StRestart;
      end
      StRestart: begin
        // Commit edge counts as the first cycle of the low-enable window.
        if (rst_q == '0) begin
          en_d    = 1'b1;
          state_d = StHunt;
        end else begin
          rst_d = rst_q - RstW'(1);
        end
      end
      default: state_d = StHunt;
    endcase
    // Inter-byte timeout; a transfer in the expiring cycle takes priority.
    if (active && !xfer) begin
      if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
        err_inc = 1'b1;
        state_d = StHunt;
      end else begin
        tmo_d = tmo_q + TmoW'(1);
      end
    end
    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  // Control and status registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= StHunt;
      idx_q   <= '0;
      xor_q   <= '0;
      load_q  <= 1'b0;
      tmo_q   <= '0;
      rst_q   <= '0;
      en_q    <= 1'b0;
      id_q    <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      xor_q   <= xor_d;
      load_q  <= load_d;
      tmo_q   <= tmo_d;
      rst_q   <= rst_d;
      en_q    <= en_d;
      id_q    <= id_d;
      err_q   <= err_d;
    end
  end

  // Shadow capture of payload bytes; live job copy updated only on commit.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < PayloadLen; i++) begin
        shadow_q[i] <= '0;
        job_q[i]    <= '0;
      end
    end else begin
      if (shadow_we) shadow_q[idx_q] <= i_rx_data;
      if (commit) begin
        for (int i = 0; i < PayloadLen; i++) job_q[i] <= shadow_q[i];
      end
    end
  end

  // Map the committed payload image onto the job field outputs.
  always_comb begin
    o_d1    = job_q[0];
    o_d2    = job_q[1];
    o_flags = job_q[6];
    for (int i = 0; i < 4; i++) begin
      o_op[i]     = job_q[2 + i];
      o_expire[i] = job_q[7 + i];
    end
    for (int i = 0; i < 32; i++) begin
      o_myaddr[i] = job_q[11 + i];
      o_rdata[i]  = job_q[43 + i];
      o_target[i] = job_q[91 + i];
    end
    for (int i = 0; i < 16; i++) o_pseed[i] = job_q[75 + i];
    o_enable  = en_q;
    o_job_id  = id_q;
    o_err_cnt = err_q;
  end

endmodule

// File: tb/tb_job_loader.sv
// Testbench for job_loader: directed frame sequences with random payloads and gaps,
// checked against a frame-level model of the expected job, enable, id and error count.
module tb_job_loader;

  logic             i_clk = 1'b0;
  logic             i_reset = 1'b1;
  logic [7:0]       i_rx_data = 8'h00;
  logic             i_rx_valid = 1'b0;
  logic             o_rx_ready;
  logic [7:0]       o_d1, o_d2, o_flags, o_job_id, o_err_cnt;
  logic [3:0][7:0]  o_op, o_expire;
  logic [31:0][7:0] o_myaddr, o_rdata, o_target;
  logic [15:0][7:0] o_pseed;
  logic             o_enable;

  always #5 i_clk = ~i_clk;

  job_loader #(.TIMEOUT_CYCLES(16), .RESTART_CYCLES(2)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_rx_data  (i_rx_data),
    .i_rx_valid (i_rx_valid),
    .o_rx_ready (o_rx_ready),
    .o_d1       (o_d1),
    .o_d2       (o_d2),
    .o_op       (o_op),
    .o_flags    (o_flags),
    .o_expire   (o_expire),
    .o_myaddr   (o_myaddr),
    .o_rdata    (o_rdata),
    .o_pseed    (o_pseed),
    .o_target   (o_target),
    .o_enable   (o_enable),
    .o_job_id   (o_job_id),
    .o_err_cnt  (o_err_cnt)
  );

  int         total = 0;
  int         bad = 0;
  logic [7:0] pl [123];
  logic [7:0] ej [123];
  logic       exp_en;
  logic [7:0] exp_id, exp_err;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [3:0][7:0]  e_op, e_ex;
    logic [31:0][7:0] e_ma, e_rd, e_tg;
    logic [15:0][7:0] e_ps;
    for (int i = 0; i < 4; i++) begin
      e_op[i] = ej[2 + i];
      e_ex[i] = ej[7 + i];
    end
    for (int i = 0; i < 32; i++) begin
      e_ma[i] = ej[11 + i];
      e_rd[i] = ej[43 + i];
      e_tg[i] = ej[91 + i];
    end
    for (int i = 0; i < 16; i++) e_ps[i] = ej[75 + i];
    chk({tag, ".d1"}, o_d1, ej[0]);
    chk({tag, ".d2"}, o_d2, ej[1]);
    chk({tag, ".op"}, o_op, e_op);
    chk({tag, ".flags"}, o_flags, ej[6]);
    chk({tag, ".expire"}, o_expire, e_ex);
    chk({tag, ".myaddr"}, o_myaddr, e_ma);
    chk({tag, ".rdata"}, o_rdata, e_rd);
    chk({tag, ".pseed"}, o_pseed, e_ps);
    chk({tag, ".target"}, o_target, e_tg);
    chk({tag, ".enable"}, o_enable, exp_en);
    chk({tag, ".job_id"}, o_job_id, exp_id);
    chk({tag, ".err_cnt"}, o_err_cnt, exp_err);
  endtask

  // Present one byte after an idle gap; returns at the negedge after it transfers.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    i_rx_valid = 1'b0;
    repeat (gap) @(negedge i_clk);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    t = 0;
    while (o_rx_ready !== 1'b1 && t < 50) begin
      @(negedge i_clk);
      t++;
    end
    if (t >= 50) chk("ready_wait", o_rx_ready, 1);
    @(negedge i_clk);
    i_rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input int n, input logic [7:0] flip,
                            input int gmax);
    logic [7:0] cs;
    cs = cmd;
    send_byte(8'hA5, $urandom_range(0, gmax));
    send_byte(cmd, $urandom_range(0, gmax));
    for (int i = 0; i < n; i++) begin
      send_byte(pl[i], $urandom_range(0, gmax));
      cs = cs ^ pl[i];
    end
    send_byte(cs ^ flip, $urandom_range(0, gmax));
  endtask

  task automatic rand_payload(input int n_a5);
    for (int i = 0; i < 123; i++) pl[i] = 8'($urandom);
    for (int i = 0; i < n_a5; i++) pl[$urandom_range(0, 122)] = 8'hA5;
  endtask

  // Good LOAD: old job until commit edge, then new job with a 2-cycle low enable.
  task automatic expect_load_ok(input string tag);
    check_all({tag, ".pre"});
    chk({tag, ".pre.ready"}, o_rx_ready, 0);
    @(negedge i_clk);
    for (int i = 0; i < 123; i++) ej[i] = pl[i];
    exp_en = 1'b0;
    exp_id = exp_id + 8'd1;
    check_all({tag, ".commit"});
    @(negedge i_clk);
    chk({tag, ".hold.enable"}, o_enable, 0);
    chk({tag, ".hold.ready"}, o_rx_ready, 0);
    @(negedge i_clk);
    exp_en = 1'b1;
    check_all({tag, ".run"});
    chk({tag, ".run.ready"}, o_rx_ready, 1);
  endtask

  task automatic expect_err(input string tag);
    exp_err = (exp_err == 8'hFF) ? 8'hFF : exp_err + 8'd1;
    check_all(tag);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 123; i++) ej[i] = 8'h00;
    exp_en  = 1'b0;
    exp_id  = 8'h00;
    exp_err = 8'h00;
  endtask

  initial begin
    model_reset();
    // Reset state.
    @(negedge i_clk);
    chk("reset.ready", o_rx_ready, 0);
    check_all("reset");
    i_reset = 1'b0;
    @(negedge i_clk);

    // 1: valid LOAD with known pattern.
    for (int i = 0; i < 123; i++) pl[i] = 8'(i);
    pl[0]   = 8'h11;
    pl[91]  = 8'h00;
    pl[122] = 8'hFF;
    send_frame(8'h01, 123, 8'h00, 0);
    expect_load_ok("t1");

    // 2: corrupted checksum, then a good frame.
    rand_payload(0);
    send_frame(8'h01, 123, 8'h01, 1);
    expect_err("t2.bad");
    send_frame(8'h01, 123, 8'h00, 1);
    expect_load_ok("t2.good");

    // Unknown command byte.
    send_byte(8'hA5, 0);
    send_byte(8'h07, 0);
    expect_err("badcmd");

    // 3: garbage then STOP while enabled.
    send_byte(8'h00, 0);
    send_byte(8'h5A, 0);
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    send_byte(8'h02, 0);
    exp_en = 1'b0;
    check_all("t3.stop");

    // 4: stall after payload byte 40 past the timeout.
    rand_payload(0);
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    for (int i = 0; i <= 40; i++) send_byte(pl[i], 0);
    repeat (20) @(negedge i_clk);
    expect_err("t4.timeout");
    chk("t4.ready", o_rx_ready, 1);
    rand_payload(0);
    send_frame(8'h01, 123, 8'h00, 0);
    expect_load_ok("t4.good");

    // 5: random gaps and embedded 0xA5 data bytes.
    for (int k = 0; k < 3; k++) begin
      rand_payload(6);
      send_frame(8'h01, 123, 8'h00, 10);
      expect_load_ok($sformatf("t5.%0d", k));
    end

    // 6: reset mid-payload, then a fresh frame.
    rand_payload(0);
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    for (int i = 0; i < 60; i++) send_byte(pl[i], 0);
    i_reset = 1'b1;
    @(negedge i_clk);
    model_reset();
    chk("t6.reset.ready", o_rx_ready, 0);
    check_all("t6.reset");
    i_reset = 1'b0;
    @(negedge i_clk);
    rand_payload(2);
    send_frame(8'h01, 123, 8'h00, 2);
    expect_load_ok("t6.good");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
